// File: rtl/sram_if_pkg.sv
// Shared defaults and width helpers for the SRAM request/response front-end.
// Imported by the adapter top and its response FIFO.
package sram_if_pkg;

  localparam int DEF_DATA_WIDTH   = 2;
  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO.
// Pointers wrap modulo FIFO_DEPTH, so any depth >= 1 works.
import sram_if_pkg::*;

module sram_rsp_fifo #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CW = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PW = ptr_w(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign count     = cnt_q;
  assign head_data = mem_q[rd_q];
  assign do_push   = push;
  assign do_pop    = pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = nxt(wr_q);
    if (do_pop)  rd_d = nxt(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk0) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/sram_req_rsp_adapter.sv
// Valid/ready front-end for a single-port SRAM with credit-protected
// read-response FIFO; writes produce no response.
import sram_if_pkg::*;

module sram_req_rsp_adapter #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int SW = CW + 1;

  logic                    fire;
  logic                    rd_fire;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic                    full;
  logic [CW-1:0]           fifo_cnt;
  logic [CW-1:0]           credits_q, credits_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;

  assign req_ready = rst0_n & (credits_q != '0);
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_we;

  assign csb0  = ~fire;
  assign web0  = ~(fire & req_we);
  assign addr0 = req_addr;
  assign din0  = req_wdata;

  // Oldest pipe stage lines up with dout0 being valid.
  assign push      = pipe_q[READ_LATENCY-1];
  assign rsp_valid = ~empty;
  assign pop       = rsp_ready & ~empty;

  always_comb begin
    pipe_d[0] = rd_fire;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (rd_fire && !pop)      credits_d = credits_q - CW'(1);
    else if (!rd_fire && pop) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      credits_q <= CW'(FIFO_DEPTH);
      pipe_q    <= '0;
    end else begin
      credits_q <= credits_d;
      pipe_q    <= pipe_d;
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk0     (clk0),
    .rst0_n   (rst0_n),
    .push     (push),
    .push_data(dout0),
    .pop      (pop),
    .empty    (empty),
    .full     (full),
    .count    (fifo_cnt),
    .head_data(rsp_rdata)
  );

  a_no_overflow: assert property (
    @(posedge clk0) disable iff (!rst0_n) !(push && full && !pop)
  );

  a_credit_bound: assert property (
    @(posedge clk0) disable iff (!rst0_n)
    (SW'(credits_q) + SW'(fifo_cnt)) <= SW'(FIFO_DEPTH)
  );

endmodule
